// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared types and constants for the JPEG Huffman block
//               scheduler. The RST_MARK state exists only when the
//               JPEG_RESTART_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

    localparam int BLOCK_COUNT_W = 16;
    localparam int NUM_COEFFS    = 64;
    localparam int RST_MOD       = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SELECT   = 4'd1,
        ST_START    = 4'd2,
        ST_WAIT_HI  = 4'd3,
        ST_WAIT_LO  = 4'd4,
        ST_RELEASE  = 4'd5,
        ST_FLUSH    = 4'd6,
        ST_DONE     = 4'd7
`ifdef JPEG_RESTART_EN
        ,
        ST_RST_MARK = 4'd8
`endif
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/jpeg_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_rr_picker
// Description : Combinational round-robin search. Starting at the pointer and
//               wrapping around, returns the first buffer flagged full.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_rr_picker #(
    parameter int NUM_BUFS = 2
) (
    input  logic [NUM_BUFS-1:0]         i_buf_full,
    input  logic [$clog2(NUM_BUFS)-1:0] i_ptr,
    output logic [$clog2(NUM_BUFS)-1:0] o_idx,
    output logic                        o_valid
);

    localparam int c_SEL_W = $clog2(NUM_BUFS);

    logic [c_SEL_W-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest full buffer wins.
    always_comb begin
        o_idx   = i_ptr;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            w_cand = c_SEL_W'((int'(i_ptr) + i) % NUM_BUFS);
            if (i_buf_full[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jpeg_huffman_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_huffman_block_scheduler
// Description : Steps one frame of coefficient blocks through the Huffman
//               encoder: picks a full buffer round-robin, starts the encoder,
//               waits for it to finish, releases the buffer, and flushes the
//               bit packer at end of frame.
//               Optional macro JPEG_RESTART_EN adds restart-marker handling
//               and the rst_index output.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_huffman_block_scheduler
    import jpeg_pkg::*;
#(
    parameter int NUM_BUFS         = 2,
    parameter int BLOCKS_PER_FRAME = 1200,
    parameter int RESTART_INTERVAL = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [NUM_BUFS-1:0]          buf_full,
    output logic [NUM_BUFS-1:0]          buf_release,
    output logic                         huff_start,
    output logic [$clog2(NUM_BUFS)-1:0]  huff_buf_sel,
    input  logic                         huff_busy,
    output logic                         dc_pred_reset,
    output logic                         flush_req,
    input  logic                         flush_ack,
    output logic                         frame_done,
    output logic                         busy,
    output logic [BLOCK_COUNT_W-1:0]     block_count
`ifdef JPEG_RESTART_EN
    ,
    output logic [2:0]                   rst_index
`endif
);

    localparam int                       c_SEL_W        = $clog2(NUM_BUFS);
    localparam logic [c_SEL_W-1:0]       c_LAST_BUF     = c_SEL_W'(NUM_BUFS - 1);
    localparam logic [BLOCK_COUNT_W-1:0] c_FRAME_BLOCKS = BLOCK_COUNT_W'(BLOCKS_PER_FRAME);

    sched_state_t             r_state;
    sched_state_t             w_state_nxt;
    logic [c_SEL_W-1:0]       r_sel;
    logic [c_SEL_W-1:0]       r_rr;
    logic [c_SEL_W-1:0]       w_pick_idx;
    logic [c_SEL_W-1:0]       w_rr_nxt;
    logic                     w_pick_valid;
    logic [BLOCK_COUNT_W-1:0] r_count;
    logic [BLOCK_COUNT_W-1:0] w_count_inc;
    logic                     r_busy;

`ifdef JPEG_RESTART_EN
    logic [2:0] r_rst_idx;
    logic       w_marker_due;

    // A marker is due on every interval boundary except the frame's last block.
    assign w_marker_due = ((int'(w_count_inc) % RESTART_INTERVAL) == 0);
    assign rst_index    = r_rst_idx;
`endif

    assign w_count_inc  = r_count + 1'b1;
    assign w_rr_nxt     = (r_sel == c_LAST_BUF) ? '0 : r_sel + 1'b1;
    assign huff_buf_sel = r_sel;
    assign block_count  = r_count;
    assign busy         = r_busy;

    jpeg_rr_picker #(
        .NUM_BUFS (NUM_BUFS)
    ) u_picker (
        .i_buf_full (buf_full),
        .i_ptr      (r_rr),
        .o_idx      (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and Moore/transition pulse outputs.
    always_comb begin
        w_state_nxt   = r_state;
        huff_start    = 1'b0;
        buf_release   = '0;
        dc_pred_reset = 1'b0;
        flush_req     = 1'b0;
        frame_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    dc_pred_reset = 1'b1;
                    w_state_nxt   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                huff_start  = 1'b1;
                w_state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (huff_busy) begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!huff_busy) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                buf_release[r_sel] = 1'b1;
                if (w_count_inc == c_FRAME_BLOCKS) begin
                    w_state_nxt = ST_FLUSH;
`ifdef JPEG_RESTART_EN
                end else if (w_marker_due) begin
                    w_state_nxt = ST_RST_MARK;
`endif
                end else begin
                    w_state_nxt = ST_SELECT;
                end
            end
            ST_FLUSH: begin
                flush_req = 1'b1;
                if (flush_ack) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`ifdef JPEG_RESTART_EN
            ST_RST_MARK: begin
                // Pad to a byte boundary first, then restart DC prediction.
                flush_req = 1'b1;
                if (flush_ack) begin
                    dc_pred_reset = 1'b1;
                    w_state_nxt   = ST_SELECT;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Buffer selection, round-robin pointer, block counter and busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel   <= '0;
            r_rr    <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && frame_start) begin
                r_count <= '0;
                r_busy  <= 1'b1;
            end
            if (r_state == ST_SELECT && w_pick_valid) begin
                r_sel <= w_pick_idx;
            end
            if (r_state == ST_RELEASE) begin
                r_count <= w_count_inc;
                r_rr    <= w_rr_nxt;
            end
            if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

`ifdef JPEG_RESTART_EN
    // Restart marker number: cleared per frame, advanced once per marker.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rst_idx <= '0;
        end else if (r_state == ST_IDLE && frame_start) begin
            r_rst_idx <= '0;
        end else if (r_state == ST_RST_MARK && flush_ack) begin
            r_rst_idx <= r_rst_idx + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_jpeg_huffman_block_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_huffman_block_scheduler
// Description : Self-checking bench for jpeg_huffman_block_scheduler
//               (NUM_BUFS=2, BLOCKS_PER_FRAME=4). Honours JPEG_RESTART_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_huffman_block_scheduler;

    localparam int c_NB  = 2;
    localparam int c_BPF = 4;
    localparam int c_RI  = 2;
`ifdef JPEG_RESTART_EN
    localparam int c_MARKS = (c_BPF - 1) / c_RI;
`else
    localparam int c_MARKS = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [1:0]  buf_full;
    logic [1:0]  buf_release;
    logic        huff_start;
    logic [0:0]  huff_buf_sel;
    logic        huff_busy;
    logic        dc_pred_reset;
    logic        flush_req;
    logic        flush_ack;
    logic        frame_done;
    logic        busy;
    logic [15:0] block_count;
`ifdef JPEG_RESTART_EN
    logic [2:0]  rst_index;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_rr     = 0;
    int m_count  = 0;
    int m_rst    = 0;
    int n_hs = 0, n_rel = 0, n_dcr = 0, n_fd = 0;

    typedef struct {
        logic [1:0] mask;
        int         exp_sel;
        int         blen;
    } vec_t;

    vec_t vecs [8];

    jpeg_huffman_block_scheduler #(
        .NUM_BUFS         (c_NB),
        .BLOCKS_PER_FRAME (c_BPF),
        .RESTART_INTERVAL (c_RI)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_start   (frame_start),
        .buf_full      (buf_full),
        .buf_release   (buf_release),
        .huff_start    (huff_start),
        .huff_buf_sel  (huff_buf_sel),
        .huff_busy     (huff_busy),
        .dc_pred_reset (dc_pred_reset),
        .flush_req     (flush_req),
        .flush_ack     (flush_ack),
        .frame_done    (frame_done),
        .busy          (busy),
        .block_count   (block_count)
`ifdef JPEG_RESTART_EN
        ,
        .rst_index     (rst_index)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse counters, sampled well after the falling edge.
    always begin
        @(negedge clock);
        #2;
        if (huff_start)    n_hs++;
        if (|buf_release)  n_rel++;
        if (dc_pred_reset) n_dcr++;
        if (frame_done)    n_fd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin choice computed from the rule: nearest full buffer at or after rr.
    function automatic int model_pick(input logic [1:0] mask);
        for (int i = 0; i < c_NB; i++) begin
            int idx = (m_rr + i) % c_NB;
            if (((mask >> idx) & 2'b01) != 2'b00) return idx;
        end
        return -1;
    endfunction

    task automatic start_frame(output int t_ref);
        frame_start = 1'b1;
        t_ref = cyc;
        #1;
        chk("dc_pred_reset_at_start", dc_pred_reset, 1);
        @(negedge clock);
        frame_start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("count_cleared", block_count, 0);
        m_count = 0;
        m_rst   = 0;
    endtask

    task automatic do_block(input logic [1:0] mask, input int blen, input int exp_sel,
                            input bit keep, input bit chk_lat, input int t_ref,
                            input bit poke_fs, output int t_rel);
        buf_full = mask;
        for (int k = 0; k < 100 && !huff_start; k++) @(negedge clock);
        chk("huff_start_seen", huff_start, 1);
        if (chk_lat) chk("start_latency", cyc - t_ref, 2);
        chk("huff_buf_sel", huff_buf_sel, exp_sel);
        chk("busy_in_block", busy, 1);
        @(negedge clock);
        chk("huff_start_one_cycle", huff_start, 0);
        huff_busy = 1'b1;
        if (!keep) buf_full = ~mask;
        @(negedge clock);
        if (poke_fs) begin
            frame_start = 1'b1;
            #1;
            chk("fs_ignored_dcr", dc_pred_reset, 0);
            @(negedge clock);
            frame_start = 1'b0;
            chk("fs_ignored_count", block_count, m_count);
        end
        repeat (blen) @(negedge clock);
        chk("sel_stable", huff_buf_sel, exp_sel);
        chk("no_early_release", buf_release, 0);
        huff_busy = 1'b0;
        for (int k = 0; k < 10 && buf_release == 2'b00; k++) @(negedge clock);
        chk("buf_release", buf_release, 32'd1 << exp_sel);
        chk("count_before_release", block_count, m_count);
        m_count++;
        m_rr  = (exp_sel + 1) % c_NB;
        t_rel = cyc;
        if (!keep) buf_full = 2'b00;
        @(negedge clock);
        chk("release_one_cycle", buf_release, 0);
        chk("block_count", block_count, m_count);
`ifdef JPEG_RESTART_EN
        if (m_count % c_RI == 0 && m_count != c_BPF) begin
            chk("rst_flush_req", flush_req, 1);
            flush_ack = 1'b1;
            #1;
            chk("rst_dc_pred_reset", dc_pred_reset, 1);
            @(negedge clock);
            flush_ack = 1'b0;
            m_rst = (m_rst + 1) % 8;
            chk("rst_index", rst_index, m_rst);
            t_rel = cyc - 1;
        end
`endif
    endtask

    task automatic finish_frame(input int ack_delay);
        chk("flush_req", flush_req, 1);
        repeat (ack_delay) @(negedge clock);
        chk("flush_req_held", flush_req, 1);
        chk("no_early_done", frame_done, 0);
        flush_ack = 1'b1;
        @(negedge clock);
        flush_ack = 1'b0;
        chk("frame_done", frame_done, 1);
        chk("flush_req_dropped", flush_req, 0);
        @(negedge clock);
        chk("frame_done_one_cycle", frame_done, 0);
        chk("busy_cleared", busy, 0);
        chk("final_count", block_count, c_BPF);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_buf_release"}, buf_release, 0);
        chk({tag, "_huff_start"}, huff_start, 0);
        chk({tag, "_huff_buf_sel"}, huff_buf_sel, 0);
        chk({tag, "_dc_pred_reset"}, dc_pred_reset, 0);
        chk({tag, "_flush_req"}, flush_req, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_block_count"}, block_count, 0);
`ifdef JPEG_RESTART_EN
        chk({tag, "_rst_index"}, rst_index, 0);
`endif
    endtask

    initial begin
        int t;
        int hs0, rel0, dcr0, fd0;
        int sel;
        bit keep;

        vecs[0] = '{2'b11, 0, 3};
        vecs[1] = '{2'b11, 1, 5};
        vecs[2] = '{2'b11, 0, 2};
        vecs[3] = '{2'b11, 1, 4};
        vecs[4] = '{2'b10, 1, 3};
        vecs[5] = '{2'b01, 0, 6};
        vecs[6] = '{2'b01, 0, 2};
        vecs[7] = '{2'b11, 1, 3};

        reset = 1'b1; frame_start = 1'b0; buf_full = 2'b00;
        huff_busy = 1'b0; flush_ack = 1'b0;
        repeat (3) @(negedge clock);
        chk_all_zero("in_reset");
        reset = 1'b0;
        @(negedge clock);
        chk_all_zero("after_reset");

        // Buffer 0 permanently full, long encoder busy.
        hs0 = n_hs; rel0 = n_rel; dcr0 = n_dcr; fd0 = n_fd;
        buf_full = 2'b01;
        start_frame(t);
        for (int b = 0; b < c_BPF; b++) do_block(2'b01, 70, 0, 1'b1, 1'b1, t, 1'b0, t);
        finish_frame(3);
        chk("s1_huff_starts", n_hs - hs0, c_BPF);
        chk("s1_releases", n_rel - rel0, c_BPF);
        chk("s1_dc_resets", n_dcr - dcr0, 1 + c_MARKS);
        chk("s1_frame_done", n_fd - fd0, 1);

        // Starved start, ignored frame_start, then reset during WAIT_LO.
        buf_full = 2'b00;
        hs0 = n_hs; rel0 = n_rel;
        start_frame(t);
        repeat (50) @(negedge clock);
        chk("starved_no_start", n_hs - hs0, 0);
        chk("starved_busy", busy, 1);
        sel = model_pick(2'b01);
        do_block(2'b01, 5, sel, 1'b0, 1'b0, t, 1'b1, t);
        buf_full = 2'b10;
        sel = model_pick(2'b10);
        for (int k = 0; k < 100 && !huff_start; k++) @(negedge clock);
        chk("pre_reset_sel", huff_buf_sel, sel);
        @(negedge clock);
        huff_busy = 1'b1;
        rel0 = n_rel;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clock);
        chk_all_zero("mid_reset_next");
        chk("mid_reset_no_release", n_rel - rel0, 0);
        reset = 1'b0; huff_busy = 1'b0; buf_full = 2'b00;
        m_rr = 0; m_count = 0;
        @(negedge clock);

        // Table-driven ping-pong frames.
        for (int i = 0; i < 8; i++) begin
            if (i % c_BPF == 0) start_frame(t);
            do_block(vecs[i].mask, vecs[i].blen, vecs[i].exp_sel, 1'b0, 1'b0, t, 1'b0, t);
            if (i % c_BPF == c_BPF - 1) finish_frame(i);
        end

        // Randomized frames against the round-robin model.
        for (int f = 0; f < 3; f++) begin
            hs0 = n_hs; fd0 = n_fd;
            start_frame(t);
            keep = 1'b0;
            for (int b = 0; b < c_BPF; b++) begin
                logic [1:0] m;
                m = 2'($urandom_range(1, 3));
                sel = model_pick(m);
                do_block(m, int'($urandom_range(1, 12)), sel, keep, keep, t, 1'b0, t);
                keep = 1'($urandom_range(0, 1));
                if (keep) buf_full = 2'($urandom_range(1, 3));
                if (keep) buf_full = m;
            end
            finish_frame(int'($urandom_range(0, 5)));
            chk("rand_huff_starts", n_hs - hs0, c_BPF);
            chk("rand_frame_done", n_fd - fd0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
